// File: rtl/io_mmio.sv
// io_mmio: memory-mapped I/O block for the 0x8xxx_xxxx region.
// Provides UART TX/RX access, a free-running cycle counter and a
// retired-instruction counter. Loads return data one cycle later.
// Optional feature macro: IO_RX_FIFO_EN selects a RX_FIFO_DEPTH-entry
// circular RX FIFO; without it the RX buffer is a single holding register.
module io_mmio #(
  parameter int CLOCK_FREQ    = 50_000_000,
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  input  logic        inst_retired,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  // Elaboration-time sanity checks on the parameters.
  if (CLOCK_FREQ <= 0) begin : g_bad_clk
    $error("io_mmio: CLOCK_FREQ must be positive");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_mmio: RX_FIFO_DEPTH must be a power of two >= 2");
  end

  // Word offsets (io_addr[7:2]) of the registers.
  localparam logic [5:0] OFF_STAT = 6'h00;
  localparam logic [5:0] OFF_RXD  = 6'h01;
  localparam logic [5:0] OFF_TXD  = 6'h02;
  localparam logic [5:0] OFF_CYC  = 6'h04;
  localparam logic [5:0] OFF_INST = 6'h05;
  localparam logic [5:0] OFF_CLR  = 6'h06;

  logic       sel;
  logic [5:0] off;
  logic       rx_pop_req;
  logic       tx_wr;
  logic       cnt_clr;

  assign sel        = (io_addr[31:28] == 4'h8);
  assign off        = io_addr[7:2];
  assign rx_pop_req = sel && io_re && (off == OFF_RXD);
  assign tx_wr      = sel && io_we && (off == OFF_TXD);
  assign cnt_clr    = sel && io_we && (off == OFF_CLR);

  // Address bits outside the decoded fields and the upper store bytes.
  logic unused_bits;
  assign unused_bits = ^{io_addr[27:8], io_addr[1:0], io_wdata[31:8]};

  logic        rdy_en_q;
  logic        rx_avail;
  logic        rx_full;
  logic [7:0]  rx_head;
  logic        rx_push;
  logic        rx_pop;

  // RX is only accepted once the first clock after reset has been seen.
  assign uart_rx_ready = rdy_en_q && !rx_full;
  assign rx_push       = uart_rx_valid && uart_rx_ready;
  assign rx_pop        = rx_pop_req && rx_avail;

  // Gate for uart_rx_ready: low in reset, high from the first cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= 1'b1;
  end

`ifdef IO_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic [7:0]  mem_q [RX_FIFO_DEPTH];

  assign rx_avail = (wptr_q != rptr_q);
  assign rx_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rx_head  = mem_q[rptr_q[AW-1:0]];

  // FIFO pointers; extra MSB distinguishes full from empty and wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (rx_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (rx_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (rx_push) mem_q[wptr_q[AW-1:0]] <= uart_rx_data;
  end
`else
  logic       rx_full_q;
  logic [7:0] rx_hold_q;

  assign rx_avail = rx_full_q;
  assign rx_full  = rx_full_q;
  assign rx_head  = rx_hold_q;

  // Holding-register occupancy; push only when empty, pop only when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rx_full_q <= 1'b0;
    else if (rx_push) rx_full_q <= 1'b1;
    else if (rx_pop)  rx_full_q <= 1'b0;
  end

  // Holding-register data; qualified by rx_full_q when read.
  always_ff @(posedge clk) begin
    if (rx_push) rx_hold_q <= uart_rx_data;
  end
`endif

  logic        tx_pend_q, tx_pend_d;
  logic [7:0]  tx_data_q, tx_data_d;

  assign uart_tx_valid = tx_pend_q;
  assign uart_tx_data  = tx_data_q;

  // TX next state: handshake frees the register; writes while busy are dropped.
  always_comb begin
    tx_pend_d = tx_pend_q;
    tx_data_d = tx_data_q;
    if (tx_pend_q && uart_tx_ready) begin
      tx_pend_d = 1'b0;
    end else if (tx_wr && !tx_pend_q) begin
      tx_pend_d = 1'b1;
      tx_data_d = io_wdata[7:0];
    end
  end

  // TX holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_pend_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_pend_q <= tx_pend_d;
      tx_data_q <= tx_data_d;
    end
  end

  logic [31:0] cyc_q, cyc_d;
  logic [31:0] inst_q, inst_d;

  // Counter next state: a clear write overrides the increment.
  always_comb begin
    cyc_d  = cyc_q + 32'd1;
    inst_d = inst_q + {31'd0, inst_retired};
    if (cnt_clr) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  // Cycle and retired-instruction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
    end
  end

  logic [31:0] rd_mux;

  // Read mux over pre-edge state; unmapped and write-only offsets read 0.
  always_comb begin
    rd_mux = '0;
    if (sel) begin
      case (off)
        OFF_STAT: rd_mux = {30'd0, rx_avail, !tx_pend_q};
        OFF_RXD:  rd_mux = rx_avail ? {24'd0, rx_head} : 32'd0;
        OFF_CYC:  rd_mux = cyc_q;
        OFF_INST: rd_mux = inst_q;
        default:  rd_mux = '0;
      endcase
    end
  end

  logic [31:0] rdata_q;
  assign io_rdata = rdata_q;

  // Registered load data, held until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_q <= '0;
    else if (io_re) rdata_q <= rd_mux;
  end

endmodule
